// File: rtl/proc_core_mc_if.sv
// proc_core_mc_if: instruction-memory and data I/O bundle of proc_core_mc.
interface proc_core_mc_if #(parameter int DATA_W = 16, parameter int PC_W = 8);
  logic [PC_W-1:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic halted;
  modport master(output imem_addr, dout, halted, input imem_rdata, din);
  modport slave(input imem_addr, dout, halted, output imem_rdata, din);
endinterface

// File: rtl/proc_core_mc.sv
// proc_core_mc: multi-cycle fetch/load/exec/next core with a 32-entry register file.
// Define PROC_MUL_EN to build the multiplier and the SGPR high-half register.
module proc_core_mc #(
  parameter int DATA_W = 16,
  parameter int PC_W = 8
) (
  input logic clk,
  input logic reset,
  proc_core_mc_if.master bus
);
  typedef enum logic [2:0] {FETCH, LOAD, EXEC, NEXT, HALT} state_t;
  state_t state, state_nx;
  logic [PC_W-1:0] pc;
  logic [31:0] ir;
  logic [DATA_W-1:0] gpr [32];
  logic [DATA_W-1:0] sgpr, a, b, res, dout;
  logic s, z, c, v, fc, fv, wr, fl, take, halted;
  logic [4:0] op, rd, rs1, rs2;
  logic imm;
  logic [15:0] isrc;
  assign {op, rd, rs1, imm} = ir[31:16];
  assign rs2 = ir[15:11];
  assign isrc = ir[15:0];
  assign a = gpr[rs1];
  assign b = imm ? DATA_W'(isrc) : gpr[rs2];
  assign take = op == 5'd14 || (op == 5'd15 && c) || (op == 5'd16 && z) ||
                (op == 5'd17 && s) || (op == 5'd18 && v);
  assign bus.imem_addr = pc;
  assign bus.dout = dout;
  assign bus.halted = halted;
`ifdef PROC_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  always_ff @(posedge clk or negedge reset)
    if (!reset) sgpr <= '0;
    else if (state == EXEC && op == 5'd4) sgpr <= prod[2*DATA_W-1:DATA_W];
`else
  assign sgpr = '0;
`endif
  always_comb begin
    res = '0;
    fc = 1'b0;
    fv = 1'b0;
    wr = 1'b0;
    fl = 1'b0;
    case (op)
      5'd0: begin res = sgpr; wr = 1'b1; end
      5'd1: begin res = imm ? b : a; wr = 1'b1; end
      5'd2: begin
        {fc, res} = {1'b0, a} + {1'b0, b};
        fv = (a[DATA_W-1] == b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
        wr = 1'b1; fl = 1'b1;
      end
      5'd3: begin
        res = a - b;
        fc = a < b;
        fv = (a[DATA_W-1] != b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
        wr = 1'b1; fl = 1'b1;
      end
`ifdef PROC_MUL_EN
      5'd4: begin
        res = prod[DATA_W-1:0];
        fc = |prod[2*DATA_W-1:DATA_W];
        wr = 1'b1; fl = 1'b1;
      end
`endif
      5'd5: begin res = a | b; wr = 1'b1; fl = 1'b1; end
      5'd6: begin res = a & b; wr = 1'b1; fl = 1'b1; end
      5'd7: begin res = a ^ b; wr = 1'b1; fl = 1'b1; end
      5'd8: begin res = ~(a ^ b); wr = 1'b1; fl = 1'b1; end
      5'd9: begin res = ~(a & b); wr = 1'b1; fl = 1'b1; end
      5'd10: begin res = ~(a | b); wr = 1'b1; fl = 1'b1; end
      5'd11: begin res = ~a; wr = 1'b1; fl = 1'b1; end
      5'd12: begin res = bus.din; wr = 1'b1; end
      default: res = '0;
    endcase
  end
  always_comb begin
    state_nx = state;
    case (state)
      FETCH: state_nx = LOAD;
      LOAD: state_nx = EXEC;
      EXEC: state_nx = op == 5'd19 ? HALT : NEXT;
      NEXT: state_nx = FETCH;
      default: state_nx = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= '0;
      ir <= '0;
      dout <= '0;
      halted <= 1'b0;
      {s, z, c, v} <= 4'b0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      if (state == LOAD) ir <= bus.imem_rdata;
      if (state == NEXT) pc <= take ? PC_W'(isrc) : pc + 1'b1;
      if (state == EXEC) begin
        if (wr) gpr[rd] <= res;
        if (fl) {s, z, c, v} <= {res[DATA_W-1], res == '0, fc, fv};
        if (op == 5'd13) dout <= a;
        if (op == 5'd19) halted <= 1'b1;
      end
    end
endmodule
